// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control FSM: state encoding, instruction classes,
// opcode/op field values and datapath select codes.
package cpu_ctrl_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned OP_W  = 2;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_ADD    = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP    = 2'b01;
  localparam logic [OP_W-1:0] OP_AND    = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN    = 2'b11;
  localparam logic [OP_W-1:0] OP_MOVIMM = 2'b10;
  localparam logic [OP_W-1:0] OP_MOVREG = 2'b00;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  typedef enum logic [2:0] {
    StWait   = 3'd0,
    StDecode = 3'd1,
    StGetA   = 3'd2,
    StGetB   = 3'd3,
    StOp     = 3'd4,
    StWreg   = 3'd5,
    StWimm   = 3'd6,
    StHalt   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ClsMovi    = 3'd0,
    ClsMovr    = 3'd1,
    ClsAlu2    = 3'd2,
    ClsMvn     = 3'd3,
    ClsCmp     = 3'd4,
    ClsIllegal = 3'd5
  } insn_class_t;

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction-side handshake plus datapath control strobes of the CPU control FSM.
// master = controller, slave = decoder/datapath side.
interface cpu_ctrl_fsm_if;
  import cpu_ctrl_pkg::*;

  logic             s;
  logic [OPC_W-1:0] opcode;
  logic [OP_W-1:0]  op;
  logic             w;
  logic [2:0]       nsel;
  logic [1:0]       vsel;
  logic             loada;
  logic             loadb;
  logic             loadc;
  logic             loads;
  logic             asel;
  logic             bsel;
  logic             write;
  logic             halt;

  modport master (
    input  s, opcode, op,
    output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, halt
  );

  modport slave (
    output s, opcode, op,
    input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, halt
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational classifier: captured opcode/op fields -> instruction class.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opc_i,
  input  logic [OP_W-1:0]  op_i,
  output insn_class_t      cls_o
);

  always_comb begin
    cls_o = ClsIllegal;
    if (opc_i == OPC_MOV) begin
      if (op_i == OP_MOVIMM) begin
        cls_o = ClsMovi;
      end else if (op_i == OP_MOVREG) begin
        cls_o = ClsMovr;
      end
    end else if (opc_i == OPC_ALU) begin
      case (op_i)
        OP_ADD, OP_AND: cls_o = ClsAlu2;
        OP_CMP:         cls_o = ClsCmp;
        OP_MVN:         cls_o = ClsMvn;
        default:        cls_o = ClsIllegal;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Moore controller sequencing regfile, A/B/C registers, ALU and status for one instruction.
// Define CPU_CTRL_ILLEGAL_TRAP_EN to trap illegal instructions in a sticky HALT state.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  cpu_ctrl_fsm_if.master bus
);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [OP_W-1:0]  op_q, op_d;
  insn_class_t      cls;

  cpu_ctrl_decode u_decode (
    .opc_i (opc_q),
    .op_i  (op_q),
    .cls_o (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      opc_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    op_d    = op_q;
    case (state_q)
      StWait: begin
        if (bus.s) begin
          opc_d   = bus.opcode;
          op_d    = bus.op;
          state_d = StDecode;
        end
      end
      StDecode: begin
        case (cls)
          ClsMovi:         state_d = StWimm;
          ClsMovr, ClsMvn: state_d = StGetB;
          ClsAlu2, ClsCmp: state_d = StGetA;
          default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            state_d = StHalt;
`else
            state_d = StWait;
`endif
          end
        endcase
      end
      StGetA:         state_d = StGetB;
      StGetB:         state_d = StOp;
      StOp:           state_d = (cls == ClsCmp) ? StWait : StWreg;
      StWreg, StWimm: state_d = StWait;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt:         state_d = StHalt;
`endif
      // Unreachable encodings (including StHalt when the trap is disabled) recover here.
      default:        state_d = StWait;
    endcase
  end

  always_comb begin
    bus.w     = 1'b0;
    bus.nsel  = NSEL_NONE;
    bus.vsel  = VSEL_C;
    bus.loada = 1'b0;
    bus.loadb = 1'b0;
    bus.loadc = 1'b0;
    bus.loads = 1'b0;
    bus.asel  = 1'b0;
    bus.bsel  = 1'b0;
    bus.write = 1'b0;
    bus.halt  = 1'b0;
    case (state_q)
      StWait: bus.w = 1'b1;
      StGetA: begin
        bus.nsel  = NSEL_RN;
        bus.loada = 1'b1;
      end
      StGetB: begin
        bus.nsel  = NSEL_RM;
        bus.loadb = 1'b1;
      end
      StOp: begin
        if (cls == ClsCmp) begin
          bus.loads = 1'b1;
        end else begin
          bus.loadc = 1'b1;
          bus.asel  = (cls == ClsMovr);
        end
      end
      StWreg: begin
        bus.nsel  = NSEL_RD;
        bus.vsel  = VSEL_C;
        bus.write = 1'b1;
      end
      StWimm: begin
        bus.nsel  = NSEL_RN;
        bus.vsel  = VSEL_IMM;
        bus.write = 1'b1;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt: bus.halt = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed per-cycle vectors push expected outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_cpu_ctrl_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;

  cpu_ctrl_fsm_if bus ();

  cpu_ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] exp;
    string       tag;
  } sb_item_t;

  sb_item_t sb_q[$];
  sb_item_t item;
  int n_checks = 0;
  int n_fail = 0;

  // Packing: {w, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel, bsel, write, halt}
  function automatic logic [13:0] ex(input bit w, input logic [2:0] nsel, input logic [1:0] vsel,
                                     input bit la, input bit lb, input bit lc, input bit ls,
                                     input bit as, input bit wr, input bit h);
    return {w, nsel, vsel, la, lb, lc, ls, as, 1'b0, wr, h};
  endfunction

  localparam logic [13:0] E_WAIT = ex(1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [13:0] E_DEC  = ex(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [13:0] E_GETA = ex(0, 3'b001, 2'b00, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [13:0] E_GETB = ex(0, 3'b100, 2'b00, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [13:0] E_OPC  = ex(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [13:0] E_OPMR = ex(0, 3'b000, 2'b00, 0, 0, 1, 0, 1, 0, 0);
  localparam logic [13:0] E_OPCM = ex(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0, 0);
  localparam logic [13:0] E_WREG = ex(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1, 0);
  localparam logic [13:0] E_WIMM = ex(0, 3'b001, 2'b10, 0, 0, 0, 0, 0, 1, 0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  localparam logic [13:0] E_HALT = ex(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 1);
`endif

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input bit r, input bit sv, input logic [2:0] oc, input logic [1:0] o,
                      input logic [13:0] e, input string tag);
    @(negedge clk);
    reset      = r;
    bus.s      = sv;
    bus.opcode = oc;
    bus.op     = o;
    sb_q.push_back('{exp: e, tag: tag});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        item = sb_q.pop_front();
        n_checks++;
        if ({bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
             bus.bsel, bus.write, bus.halt} !== item.exp) begin
          n_fail++;
          $display("FAIL %s: got %b required %b (t=%0t)", item.tag,
                   {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc, bus.loads,
                    bus.asel, bus.bsel, bus.write, bus.halt}, item.exp, $time);
        end
      end
    end
  end

  initial begin
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;

    step(1, 0, 3'b000, 2'b00, E_WAIT, "reset0");
    step(1, 0, 3'b000, 2'b00, E_WAIT, "reset1");
    for (int i = 0; i < 5; i++) step(0, 0, 3'b110, 2'b10, E_WAIT, "idle");

    // MOV imm, with fields scrambled after capture
    step(0, 1, 3'b110, 2'b10, E_DEC,  "movi_dec");
    step(0, 0, 3'b111, 2'b11, E_WIMM, "movi_wimm");
    step(0, 0, 3'b111, 2'b11, E_WAIT, "movi_done");

    // ADD, s pulsed while busy must be ignored
    step(0, 1, 3'b101, 2'b00, E_DEC,  "add_dec");
    step(0, 0, 3'b000, 2'b00, E_GETA, "add_geta");
    step(0, 1, 3'b110, 2'b10, E_GETB, "add_getb");
    step(0, 0, 3'b000, 2'b00, E_OPC,  "add_op");
    step(0, 0, 3'b000, 2'b00, E_WREG, "add_wreg");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "add_done");

    // CMP: no write, loads in OP
    step(0, 1, 3'b101, 2'b01, E_DEC,  "cmp_dec");
    step(0, 0, 3'b000, 2'b00, E_GETA, "cmp_geta");
    step(0, 0, 3'b000, 2'b00, E_GETB, "cmp_getb");
    step(0, 0, 3'b000, 2'b00, E_OPCM, "cmp_op");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "cmp_done");

    // MOV reg: asel with loadc
    step(0, 1, 3'b110, 2'b00, E_DEC,  "movr_dec");
    step(0, 0, 3'b000, 2'b00, E_GETB, "movr_getb");
    step(0, 0, 3'b000, 2'b00, E_OPMR, "movr_op");
    step(0, 0, 3'b000, 2'b00, E_WREG, "movr_wreg");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "movr_done");

    // MVN
    step(0, 1, 3'b101, 2'b11, E_DEC,  "mvn_dec");
    step(0, 0, 3'b000, 2'b00, E_GETB, "mvn_getb");
    step(0, 0, 3'b000, 2'b00, E_OPC,  "mvn_op");
    step(0, 0, 3'b000, 2'b00, E_WREG, "mvn_wreg");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "mvn_done");

    // AND
    step(0, 1, 3'b101, 2'b10, E_DEC,  "and_dec");
    step(0, 0, 3'b000, 2'b00, E_GETA, "and_geta");
    step(0, 0, 3'b000, 2'b00, E_GETB, "and_getb");
    step(0, 0, 3'b000, 2'b00, E_OPC,  "and_op");
    step(0, 0, 3'b000, 2'b00, E_WREG, "and_wreg");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "and_done");

    // Back-to-back ADDs with s held high and opcode changing mid-instruction
    step(0, 1, 3'b101, 2'b00, E_DEC,  "b2b1_dec");
    step(0, 1, 3'b110, 2'b10, E_GETA, "b2b1_geta");
    step(0, 1, 3'b110, 2'b10, E_GETB, "b2b1_getb");
    step(0, 1, 3'b110, 2'b10, E_OPC,  "b2b1_op");
    step(0, 1, 3'b110, 2'b10, E_WREG, "b2b1_wreg");
    step(0, 1, 3'b110, 2'b10, E_WAIT, "b2b_gap");
    step(0, 1, 3'b101, 2'b00, E_DEC,  "b2b2_dec");
    step(0, 1, 3'b110, 2'b10, E_GETA, "b2b2_geta");
    step(0, 1, 3'b110, 2'b10, E_GETB, "b2b2_getb");
    step(0, 1, 3'b110, 2'b10, E_OPC,  "b2b2_op");
    step(0, 0, 3'b110, 2'b10, E_WREG, "b2b2_wreg");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "b2b2_done");

    // Reset during GETB: no write afterwards; reset also beats s
    step(0, 1, 3'b101, 2'b00, E_DEC,  "rst_dec");
    step(0, 0, 3'b000, 2'b00, E_GETA, "rst_geta");
    step(0, 0, 3'b000, 2'b00, E_GETB, "rst_getb");
    step(1, 0, 3'b000, 2'b00, E_WAIT, "rst_mid");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "rst_after");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "rst_after2");
    step(1, 1, 3'b101, 2'b00, E_WAIT, "rst_vs_s");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "rst_vs_s_after");

    // Illegal 111/00
    step(0, 1, 3'b111, 2'b00, E_DEC,  "ill_dec");
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    step(0, 0, 3'b000, 2'b00, E_HALT, "ill_halt");
    step(0, 1, 3'b110, 2'b10, E_HALT, "ill_sticky0");
    step(0, 1, 3'b110, 2'b10, E_HALT, "ill_sticky1");
    step(1, 0, 3'b000, 2'b00, E_WAIT, "ill_reset");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "ill_recovered");
`else
    step(0, 0, 3'b000, 2'b00, E_WAIT, "ill_skip");
    step(0, 0, 3'b000, 2'b00, E_WAIT, "ill_idle");
`endif

    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left required 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
